p405s_exe_strseq: RTL and testbench
===================================

Name: p405s_exe_strseq

Overview:
- String-transfer sequencer in the EXE stage for lswi/lswx/stswi/stswx.
- Sits directly downstream of the XER block. It consumes the XER transfer byte count (EXE_xerTBC[0:6]) or the instruction NB field.
- Breaks the transfer into a sequence of word-sized data-cache requests, each with a byte count of 1 to 4 and a target/source GPR number.
- Signals completion to PCL.

Parameters:
- CNT_W, 7, width of the remaining-byte counter; matches XER TBC width.
- WORD_BYTES, 4, maximum bytes per request.

Ports:
- CB  input  1  clock; all state changes on its rising edge.
- resetL2  input  1  reset, synchronous, active-high.
- PCL_exeStrStart  input  1  one-cycle start pulse for a string op.
- PCL_exeStrImm  input  1  1 = immediate form (use NB); 0 = indexed form (use TBC).
- PCL_exeStrNb  input  5  NB field; 0 encodes 32 bytes.
- EXE_xerTBC  input  7  XER byte count, sampled on start.
- PCL_exeStrRt  input  5  first GPR number.
- PCL_exeFlush  input  1  pipeline flush; aborts the operation.
- DCU_strAck  input  1  data cache accepted the current request.
- STR_reqValid  output  1  request valid.
- STR_reqBytes  output  3  bytes in this request, 1..4.
- STR_reqRt  output  5  GPR for this request.
- STR_busy  output  1  sequencer not idle; PCL holds the EXE stage.
- STR_done  output  1  one-cycle completion pulse.
- STR_zeroLen  output  1  qualifies STR_done; the count was zero.

Behaviour:
- States: IDLE, REQ, DONE. Reset → IDLE.
- All outputs are 0 in IDLE and at reset.
- IDLE + PCL_exeStrStart:
  - Load cnt = PCL_exeStrImm ? (NB==0 ? 32 : NB) : EXE_xerTBC.
  - Load rt = PCL_exeStrRt.
  - If cnt==0 → DONE with zl=1; otherwise → REQ.
- REQ:
  - STR_reqValid=1.
  - STR_reqBytes = (cnt >= 4) ? 4 : cnt[2:0].
  - STR_reqRt = rt.
  - Outputs are held stable until DCU_strAck.
- On DCU_strAck in REQ:
  - cnt ← cnt − STR_reqBytes.
  - rt ← rt + 1, modulo 32, so 31 wraps to 0.
  - If the new cnt==0 → DONE; else stay in REQ.
  - Back-to-back acks are allowed, giving one request per cycle.
- DONE:
  - STR_done=1 for exactly one cycle.
  - STR_zeroLen = zl.
  - → IDLE.
- STR_busy = (state != IDLE).
- Latency:
  - Zero-length op: done 1 cycle after start.
  - N-byte op: ceil(N/4) accepted requests, then done 1 cycle after the last ack.
- Start while busy: ignored, with no state effect. PCL guarantees it does not occur.
- PCL_exeFlush in any state: → IDLE next cycle; no STR_done, no further requests. Flush wins over a same-cycle ack or start.
- resetL2 wins over flush, start and ack. Mid-operation reset → IDLE with all outputs 0.
- Max count is 127 (TBC). The counter never underflows because reqBytes ≤ cnt.

Optional Feature:
- P405S_STRSEQ_INVFORM_EN, when defined:
  - Adds inputs PCL_exeStrRa[0:4] and PCL_exeStrLoad, and output STR_invalidForm.
  - On start of a load with cnt≠0, n = ceil(cnt/4) registers are computed.
  - If RA lies in the wrapped range [RT, RT+n−1] mod 32:
    - No requests are issued.
    - Go directly to DONE.
    - STR_invalidForm=1 during the DONE cycle.
- When undefined:
  - None of these ports exist.
  - Overlap with RA is not checked; requests are issued normally.

Decomposition:
- Package p405s_strseq_pkg holds:
  - the state encoding (IDLE/REQ/DONE);
  - WORD_BYTES = 4;
  - NB_ZERO_BYTES = 32;
  - the helper function for min(cnt, 4).
- One sub-module, p405s_strseq_dp: the cnt/rt registers with load/decrement/increment and the reqBytes computation.
- The top level holds the FSM and handshake.

Test Plan:
- lswi, NB=0, RT=5, ack every cycle → 8 requests of 4 bytes each, RT 5..12, then STR_done; zeroLen=0.
- lswx, TBC=7, RT=31, ack every cycle → request (4, rt31), then request (3, rt0), then done.
- lswx, TBC=0 → no STR_reqValid; STR_done and STR_zeroLen both 1 in the cycle after start; busy 1 for 1 cycle.
- TBC=9, ack withheld for 3 cycles on the first request → reqBytes=4 and reqRt held stable; total 3 requests (4, 4, 1).
- TBC=12, flush asserted together with the 2nd ack → IDLE next cycle; no done; cnt not decremented further.
- resetL2 asserted during REQ with TBC=20 → all outputs 0 next cycle. A new start with NB=3 then gives a single request of 3 bytes.

Source files
------------

// File: rtl/p405s_strseq_pkg.sv
// Shared types and constants for the EXE-stage string-transfer sequencer.
// The optional invalid-form check is enabled by P405S_STRSEQ_INVFORM_EN.
package p405s_strseq_pkg;

  localparam int CNT_W         = 7;
  localparam int WORD_BYTES    = 4;
  localparam int NB_ZERO_BYTES = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } strseq_state_e;

  function automatic logic [2:0] min_word_bytes(input logic [CNT_W-1:0] cnt);
    if (cnt >= CNT_W'(WORD_BYTES)) begin
      return 3'(WORD_BYTES);
    end
    return cnt[2:0];
  endfunction

endpackage

// File: rtl/p405s_strseq_dp.sv
// Remaining-byte counter and GPR pointer for the string sequencer, plus the
// per-request byte count. Controlled by the FSM in p405s_exe_strseq.
module p405s_strseq_dp
  import p405s_strseq_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_cnt,
  input  logic [4:0]       load_rt,
  input  logic             step,
  output logic [4:0]       rt,
  output logic [2:0]       req_bytes,
  output logic             last_req
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       rt_q, rt_d;

  always_comb begin
    cnt_d = cnt_q;
    rt_d  = rt_q;
    if (load) begin
      cnt_d = load_cnt;
      rt_d  = load_rt;
    end else if (step) begin
      cnt_d = cnt_q - CNT_W'(req_bytes);
      rt_d  = rt_q + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      rt_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      rt_q  <= rt_d;
    end
  end

  // The current request drains the counter when no more than a word remains.
  assign req_bytes = min_word_bytes(cnt_q);
  assign last_req  = (cnt_q <= CNT_W'(WORD_BYTES));
  assign rt        = rt_q;

endmodule

// File: rtl/p405s_exe_strseq.sv
// EXE-stage sequencer splitting lswi/lswx/stswi/stswx into word requests.
// Define P405S_STRSEQ_INVFORM_EN to add the RA-in-target-range check.
module p405s_exe_strseq
  import p405s_strseq_pkg::*;
(
  input  logic       CB,
  input  logic       resetL2,
  input  logic       PCL_exeStrStart,
  input  logic       PCL_exeStrImm,
  input  logic [4:0] PCL_exeStrNb,
  input  logic [6:0] EXE_xerTBC,
  input  logic [4:0] PCL_exeStrRt,
`ifdef P405S_STRSEQ_INVFORM_EN
  input  logic [4:0] PCL_exeStrRa,
  input  logic       PCL_exeStrLoad,
  output logic       STR_invalidForm,
`endif
  input  logic       PCL_exeFlush,
  input  logic       DCU_strAck,
  output logic       STR_reqValid,
  output logic [2:0] STR_reqBytes,
  output logic [4:0] STR_reqRt,
  output logic       STR_busy,
  output logic       STR_done,
  output logic       STR_zeroLen
);

  strseq_state_e    state_q, state_d;
  logic             zl_q, zl_d;
  logic [CNT_W-1:0] start_cnt;
  logic             dp_load, dp_step, dp_last;
  logic [4:0]       dp_rt;
  logic [2:0]       dp_bytes;
  logic             bad_form;

  p405s_strseq_dp u_dp (
    .clk       (CB),
    .reset     (resetL2),
    .load      (dp_load),
    .load_cnt  (start_cnt),
    .load_rt   (PCL_exeStrRt),
    .step      (dp_step),
    .rt        (dp_rt),
    .req_bytes (dp_bytes),
    .last_req  (dp_last)
  );

  assign start_cnt = PCL_exeStrImm
                   ? ((PCL_exeStrNb == 5'd0) ? CNT_W'(NB_ZERO_BYTES) : CNT_W'(PCL_exeStrNb))
                   : EXE_xerTBC;

`ifdef P405S_STRSEQ_INVFORM_EN
  logic       inv_q, inv_d;
  logic [7:0] n_regs;
  logic [4:0] ra_offset;

  // RA overlaps the targets when its wrapped distance from RT is below n.
  assign n_regs    = (8'(start_cnt) + 8'd3) >> 2;
  assign ra_offset = PCL_exeStrRa - PCL_exeStrRt;
  assign bad_form  = PCL_exeStrLoad && (start_cnt != '0) && (8'(ra_offset) < n_regs);

  always_comb begin
    inv_d = inv_q;
    if (state_q == ST_IDLE && PCL_exeStrStart && !PCL_exeFlush) begin
      inv_d = bad_form;
    end
  end

  always_ff @(posedge CB) begin
    if (resetL2) begin
      inv_q <= 1'b0;
    end else begin
      inv_q <= inv_d;
    end
  end

  assign STR_invalidForm = (state_q == ST_DONE) && inv_q;
`else
  assign bad_form = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    zl_d         = zl_q;
    dp_load      = 1'b0;
    dp_step      = 1'b0;
    STR_reqValid = 1'b0;
    STR_reqBytes = 3'd0;
    STR_reqRt    = 5'd0;
    STR_done     = 1'b0;
    STR_zeroLen  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (PCL_exeStrStart && !PCL_exeFlush) begin
          dp_load = 1'b1;
          zl_d    = (start_cnt == '0);
          state_d = ((start_cnt == '0) || bad_form) ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        STR_reqValid = 1'b1;
        STR_reqBytes = dp_bytes;
        STR_reqRt    = dp_rt;
        if (DCU_strAck && !PCL_exeFlush) begin
          dp_step = 1'b1;
          if (dp_last) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        STR_done    = 1'b1;
        STR_zeroLen = zl_q;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Flush abandons the op from any state, overriding start and ack.
    if (PCL_exeFlush) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge CB) begin
    if (resetL2) begin
      state_q <= ST_IDLE;
      zl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      zl_q    <= zl_d;
    end
  end

  assign STR_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_p405s_exe_strseq.sv
// Directed self-checking bench for p405s_exe_strseq.
// Inputs change and outputs are sampled on the falling edge of CB.
module tb_p405s_exe_strseq;

  logic       CB;
  logic       resetL2;
  logic       PCL_exeStrStart;
  logic       PCL_exeStrImm;
  logic [4:0] PCL_exeStrNb;
  logic [6:0] EXE_xerTBC;
  logic [4:0] PCL_exeStrRt;
  logic       PCL_exeFlush;
  logic       DCU_strAck;
  logic       STR_reqValid;
  logic [2:0] STR_reqBytes;
  logic [4:0] STR_reqRt;
  logic       STR_busy;
  logic       STR_done;
  logic       STR_zeroLen;
`ifdef P405S_STRSEQ_INVFORM_EN
  logic [4:0] PCL_exeStrRa;
  logic       PCL_exeStrLoad;
  logic       STR_invalidForm;
`endif

  int checkCount = 0;
  int errorCount = 0;

  p405s_exe_strseq dut (
    .CB              (CB),
    .resetL2         (resetL2),
    .PCL_exeStrStart (PCL_exeStrStart),
    .PCL_exeStrImm   (PCL_exeStrImm),
    .PCL_exeStrNb    (PCL_exeStrNb),
    .EXE_xerTBC      (EXE_xerTBC),
    .PCL_exeStrRt    (PCL_exeStrRt),
`ifdef P405S_STRSEQ_INVFORM_EN
    .PCL_exeStrRa    (PCL_exeStrRa),
    .PCL_exeStrLoad  (PCL_exeStrLoad),
    .STR_invalidForm (STR_invalidForm),
`endif
    .PCL_exeFlush    (PCL_exeFlush),
    .DCU_strAck      (DCU_strAck),
    .STR_reqValid    (STR_reqValid),
    .STR_reqBytes    (STR_reqBytes),
    .STR_reqRt       (STR_reqRt),
    .STR_busy        (STR_busy),
    .STR_done        (STR_done),
    .STR_zeroLen     (STR_zeroLen)
  );

  initial begin
    CB = 1'b0;
    forever #5 CB = ~CB;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " valid"},   32'(STR_reqValid), 0);
    checkOutput({tag, " bytes"},   32'(STR_reqBytes), 0);
    checkOutput({tag, " rt"},      32'(STR_reqRt),    0);
    checkOutput({tag, " busy"},    32'(STR_busy),     0);
    checkOutput({tag, " done"},    32'(STR_done),     0);
    checkOutput({tag, " zeroLen"}, 32'(STR_zeroLen),  0);
  endtask

  // Pulses start for one cycle; returns on the following falling edge.
  task automatic applyStimulus(input logic imm, input logic [4:0] nb, input logic [6:0] tbc, input logic [4:0] rt);
    PCL_exeStrImm   = imm;
    PCL_exeStrNb    = nb;
    EXE_xerTBC      = tbc;
    PCL_exeStrRt    = rt;
    PCL_exeStrStart = 1'b1;
    @(negedge CB);
    PCL_exeStrStart = 1'b0;
  endtask

  // Acks every request of a transfer of 'total' bytes, then expects done.
  task automatic runTransfer(input string tag, input int total, input logic [4:0] firstRt);
    int         remaining;
    int         expBytes;
    logic [4:0] expRt;
    remaining = total;
    expRt     = firstRt;
    while (remaining > 0) begin
      expBytes = (remaining >= 4) ? 4 : remaining;
      checkOutput({tag, " req valid"}, 32'(STR_reqValid), 1);
      checkOutput({tag, " req bytes"}, 32'(STR_reqBytes), 32'(expBytes));
      checkOutput({tag, " req rt"},    32'(STR_reqRt),    32'(expRt));
      DCU_strAck = 1'b1;
      @(negedge CB);
      DCU_strAck = 1'b0;
      remaining -= expBytes;
      expRt = expRt + 5'd1;
    end
    checkOutput({tag, " done"},       32'(STR_done),     1);
    checkOutput({tag, " zeroLen"},    32'(STR_zeroLen),  0);
    checkOutput({tag, " done valid"}, 32'(STR_reqValid), 0);
    checkOutput({tag, " done busy"},  32'(STR_busy),     1);
    @(negedge CB);
    checkIdle({tag, " after"});
  endtask

  initial begin
    resetL2         = 1'b1;
    PCL_exeStrStart = 1'b0;
    PCL_exeStrImm   = 1'b0;
    PCL_exeStrNb    = 5'd0;
    EXE_xerTBC      = 7'd0;
    PCL_exeStrRt    = 5'd0;
    PCL_exeFlush    = 1'b0;
    DCU_strAck      = 1'b0;
`ifdef P405S_STRSEQ_INVFORM_EN
    PCL_exeStrRa    = 5'd0;
    PCL_exeStrLoad  = 1'b0;
`endif
    repeat (2) @(negedge CB);
    checkIdle("reset");
    resetL2 = 1'b0;
    @(negedge CB);
    checkIdle("post-reset");

    // lswi NB=0 means 32 bytes: eight full words from r5 up to r12
    applyStimulus(1'b1, 5'd0, 7'd0, 5'd5);
    runTransfer("nb0", 32, 5'd5);

    // lswx 7 bytes starting at r31 wraps to r0
    applyStimulus(1'b0, 5'd0, 7'd7, 5'd31);
    runTransfer("tbc7", 7, 5'd31);

    // zero-length lswx: done with zeroLen the cycle after start
    applyStimulus(1'b0, 5'd0, 7'd0, 5'd9);
    checkOutput("zero valid",   32'(STR_reqValid), 0);
    checkOutput("zero done",    32'(STR_done),     1);
    checkOutput("zero zeroLen", 32'(STR_zeroLen),  1);
    checkOutput("zero busy",    32'(STR_busy),     1);
    @(negedge CB);
    checkIdle("zero after");

    // 9 bytes with the first ack withheld for three cycles
    applyStimulus(1'b0, 5'd0, 7'd9, 5'd2);
    for (int i = 0; i < 3; i++) begin
      checkOutput("stall valid", 32'(STR_reqValid), 1);
      checkOutput("stall bytes", 32'(STR_reqBytes), 4);
      checkOutput("stall rt",    32'(STR_reqRt),    2);
      @(negedge CB);
    end
    runTransfer("tbc9", 9, 5'd2);

    // 12 bytes, flush together with the second ack
    applyStimulus(1'b0, 5'd0, 7'd12, 5'd10);
    checkOutput("flush req1 bytes", 32'(STR_reqBytes), 4);
    checkOutput("flush req1 rt",    32'(STR_reqRt),    10);
    DCU_strAck = 1'b1;
    @(negedge CB);
    checkOutput("flush req2 valid", 32'(STR_reqValid), 1);
    checkOutput("flush req2 rt",    32'(STR_reqRt),    11);
    PCL_exeFlush = 1'b1;
    @(negedge CB);
    DCU_strAck   = 1'b0;
    PCL_exeFlush = 1'b0;
    checkIdle("flush next");
    @(negedge CB);
    checkIdle("flush no done");
    applyStimulus(1'b0, 5'd0, 7'd5, 5'd0);
    runTransfer("after flush", 5, 5'd0);

    // reset in the middle of a 20-byte transfer, then a 3-byte lswi
    applyStimulus(1'b0, 5'd0, 7'd20, 5'd3);
    DCU_strAck = 1'b1;
    @(negedge CB);
    DCU_strAck = 1'b0;
    checkOutput("midreset req2 rt", 32'(STR_reqRt), 4);
    resetL2 = 1'b1;
    DCU_strAck = 1'b1;
    @(negedge CB);
    resetL2 = 1'b0;
    DCU_strAck = 1'b0;
    checkIdle("midreset");
    applyStimulus(1'b1, 5'd3, 7'd0, 5'd7);
    runTransfer("nb3", 3, 5'd7);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
